// File: rtl/sprite_capture_writer.sv
// Writer side of the indexed-sprite image memory: captures one raster-ordered frame of
// palette indices per arm request and writes it into the image BRAM at y*WIDTH + x.
module sprite_capture_writer #(
    parameter int unsigned WIDTH    = 256,
    parameter int unsigned HEIGHT   = 256,
    parameter int unsigned PIX_W    = 8,
    localparam int unsigned AddrBits = $clog2(WIDTH * HEIGHT)
) (
    input  logic                pixel_clk_in,
    input  logic                rst_n_in,
    input  logic                arm_in,
    input  logic                pause_in,
    input  logic [PIX_W-1:0]    pixel_in,
    input  logic                pixel_valid_in,
    input  logic                pixel_sof_in,
    output logic                pixel_ready_out,
    output logic [AddrBits-1:0] bram_addr_out,
    output logic [PIX_W-1:0]    bram_data_out,
    output logic                bram_we_out,
    output logic                busy_out,
    output logic                done_out,
    output logic                error_out
);

    localparam int unsigned XBits = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned YBits = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XBits-1:0] XMax = XBits'(WIDTH - 1);
    localparam logic [YBits-1:0] YMax = YBits'(HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StWaitSof, StWrite, StDone} state_e;

    state_e              state_q;
    logic [XBits-1:0]    x_q;
    logic [YBits-1:0]    y_q;

    logic                accept;
    logic                write_beat;
    logic                mid_frame_sof;
    logic [XBits-1:0]    cur_x;
    logic [YBits-1:0]    cur_y;
    logic                last_pix;
    logic [AddrBits-1:0] cur_addr;

    assign pixel_ready_out = rst_n_in && !pause_in && (state_q != StDone);
    assign accept          = pixel_valid_in && pixel_ready_out;

    // A SOF beat always lands on (0,0), whether it opens the frame or restarts it.
    always_comb begin
        cur_x         = pixel_sof_in ? '0 : x_q;
        cur_y         = pixel_sof_in ? '0 : y_q;
        last_pix      = (cur_x == XMax) && (cur_y == YMax);
        cur_addr      = AddrBits'(cur_y) * AddrBits'(WIDTH) + AddrBits'(cur_x);
        write_beat    = accept && ((state_q == StWrite) ||
                                   (state_q == StWaitSof && pixel_sof_in));
        mid_frame_sof = accept && (state_q == StWrite) && pixel_sof_in &&
                        ((x_q != '0) || (y_q != '0));
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= StIdle;
            x_q           <= '0;
            y_q           <= '0;
            bram_addr_out <= '0;
            bram_data_out <= '0;
            bram_we_out   <= 1'b0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            error_out     <= 1'b0;
        end else begin
            bram_we_out <= 1'b0;
            done_out    <= 1'b0;

            if (mid_frame_sof) begin
                error_out <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (arm_in) begin
                        state_q   <= StWaitSof;
                        busy_out  <= 1'b1;
                        error_out <= 1'b0;
                    end
                end
                StWaitSof, StWrite: begin
                    if (write_beat) begin
                        bram_we_out   <= 1'b1;
                        bram_addr_out <= cur_addr;
                        bram_data_out <= pixel_in;
                        if (last_pix) begin
                            state_q  <= StDone;
                            busy_out <= 1'b0;
                            x_q      <= '0;
                            y_q      <= '0;
                        end else begin
                            state_q <= StWrite;
                            if (cur_x == XMax) begin
                                x_q <= '0;
                                y_q <= cur_y + YBits'(1);
                            end else begin
                                x_q <= cur_x + XBits'(1);
                                y_q <= cur_y;
                            end
                        end
                    end
                end
                StDone: begin
                    state_q  <= StIdle;
                    done_out <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_capture_writer.sv
// Randomized and directed bench for sprite_capture_writer: a 4x2 instance checked cycle by
// cycle against a linear-index frame model, plus a full 256x256 frame on a default instance.
module tb_sprite_capture_writer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       arm = 1'b0, pause = 1'b0, valid = 1'b0, sof = 1'b0;
    logic [7:0] pix = '0;
    logic       ready, we, busy, done, err;
    logic [2:0] addr;
    logic [7:0] data;

    logic        b_arm = 1'b0, b_pause = 1'b0, b_valid = 1'b0, b_sof = 1'b0;
    logic [7:0]  b_pix = '0;
    logic        b_ready, b_we, b_busy, b_done, b_err;
    logic [15:0] b_addr;
    logic [7:0]  b_data;

    always #5 clk = ~clk;

    sprite_capture_writer #(.WIDTH(W), .HEIGHT(H), .PIX_W(8)) dut (
        .pixel_clk_in    (clk),
        .rst_n_in        (rst_n),
        .arm_in          (arm),
        .pause_in        (pause),
        .pixel_in        (pix),
        .pixel_valid_in  (valid),
        .pixel_sof_in    (sof),
        .pixel_ready_out (ready),
        .bram_addr_out   (addr),
        .bram_data_out   (data),
        .bram_we_out     (we),
        .busy_out        (busy),
        .done_out        (done),
        .error_out       (err)
    );

    sprite_capture_writer dut_big (
        .pixel_clk_in    (clk),
        .rst_n_in        (rst_n),
        .arm_in          (b_arm),
        .pause_in        (b_pause),
        .pixel_in        (b_pix),
        .pixel_valid_in  (b_valid),
        .pixel_sof_in    (b_sof),
        .pixel_ready_out (b_ready),
        .bram_addr_out   (b_addr),
        .bram_data_out   (b_data),
        .bram_we_out     (b_we),
        .busy_out        (b_busy),
        .done_out        (b_done),
        .error_out       (b_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame model: 0 idle, 1 waiting for SOF, 2 writing, 3 done; pos is the linear index
    // of the next pixel.
    int m_st   = 0;
    int m_pos  = 0;
    bit m_err  = 1'b0;
    int wr_obs = 0;

    task automatic step(input bit a, input bit p, input bit v, input bit s,
                        input logic [7:0] d);
        bit m_rdy, acc, e_we, e_done;
        int e_addr;
        arm = a; pause = p; valid = v; sof = s; pix = d;
        #1;
        m_rdy = !p && (m_st != 3);
        check("ready", ready, m_rdy);
        acc    = v && m_rdy;
        e_we   = 1'b0;
        e_done = (m_st == 3);
        e_addr = 0;
        case (m_st)
            0: if (a) begin m_st = 1; m_err = 1'b0; end
            1: if (acc && s) begin
                e_we  = 1'b1;
                m_pos = 1;
                m_st  = (N == 1) ? 3 : 2;
            end
            2: if (acc) begin
                e_addr = s ? 0 : m_pos;
                if (s && m_pos != 0) m_err = 1'b1;
                e_we  = 1'b1;
                m_pos = e_addr + 1;
                if (m_pos == N) m_st = 3;
            end
            default: m_st = 0;
        endcase
        @(posedge clk);
        #1;
        if (we) wr_obs++;
        check("we", we, e_we);
        if (e_we) begin
            check("addr", addr, e_addr);
            check("data", data, d);
        end
        check("done", done, e_done);
        check("busy", busy, (m_st == 1) || (m_st == 2));
        check("error", err, m_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_we"}, we, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_b_ready"}, b_ready, 0);
        check({tag, "_b_we"}, b_we, 0);
        check({tag, "_b_busy"}, b_busy, 0);
    endtask

    task automatic do_reset();
        arm = 1'b0; pause = 1'b0; valid = 1'b1; sof = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        m_st = 0; m_pos = 0; m_err = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int big_errs, big_wr, done_cnt;
        logic [15:0] last_addr;

        #2;
        check_all_zero("rst_init");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // No arm: stream discarded, source never stalled.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, (i == 0) || (i == 5), 8'(i));

        // Basic frame.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, i == 0, 8'(10 + i));
        idle(3);

        // Mid-frame SOF restarts at addr 0 and sets error; next arm clears it.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, i == 0, 8'(i));
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'(20 + i));
        idle(3);
        check("err_sticky", err, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, i == 0, 8'(30 + i));
        idle(2);

        // Pause mid-frame with valid held.
        wr_obs = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, i == 0, 8'(40 + i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'(60 + i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'(50 + i));
        idle(3);
        check("pause_writes", wr_obs, 8);

        // Reset mid-frame aborts; fresh frame starts at addr 0.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, i == 0, 8'(70 + i));
        do_reset();
        idle(3);
        wr_obs = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, i == 0, 8'(80 + i));
        idle(3);
        check("post_reset_writes", wr_obs, 8);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 16) == 0, ($urandom % 6) == 0, ($urandom % 4) != 0,
                 ($urandom % 10) == 0, 8'($urandom));
        end
        idle(3);

        // Full default-size frame.
        big_errs = 0; big_wr = 0; done_cnt = 0; last_addr = '0;
        b_arm = 1'b1;
        @(posedge clk);
        #1;
        b_arm = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            b_valid = 1'b1;
            b_sof   = (i == 0);
            b_pix   = i[7:0];
            @(posedge clk);
            #1;
            if (b_we) begin
                big_wr++;
                last_addr = b_addr;
            end
            if (!b_we || b_addr != i[15:0] || b_data != i[7:0] || b_done) big_errs++;
        end
        b_valid = 1'b0;
        b_sof   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (b_done) done_cnt++;
            if (b_we) big_wr++;
        end
        check("big_seq_errs", big_errs, 0);
        check("big_writes", big_wr, 65536);
        check("big_last_addr", last_addr, 16'hFFFF);
        check("big_done_pulses", done_cnt, 1);
        check("big_busy_after", b_busy, 0);
        check("big_err", b_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
